sha256_block_loader: RTL and testbench
======================================

Name: sha256_block_loader

Overview:
- Writer side of the message scheduler's word-load interface (word data, 4-bit word address, write enable, active-low block clear).
- Accepts a 32-bit big-endian message word stream, applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length), and writes 16 words per 512-bit block into the scheduler memory.
- Hands each filled block to the round controller and holds off further writes until the controller acknowledges it.

Parameters:
- LEN_W, 64, width of the internal message bit-length counter (≤64; zero-extended into the 64-bit length field).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  loader can accept a word this cycle
- in_data  in  32  message word, first byte in [31:24]
- in_last  in  1  final word of message
- in_nbytes  in  3  valid bytes in word; 4 unless in_last; 0..4 legal with in_last
- wr_en  out  1  scheduler write strobe (write_enable_in)
- wr_addr  out  4  scheduler word address (message_word_addr)
- wr_data  out  32  scheduler word data (message_word_in)
- blk_clr_n  out  1  one-cycle active-low scheduler memory clear (reset_new_block)
- block_valid  out  1  16 words of a block written; held until block_ack
- block_last  out  1  qualifies block_valid: final block of message
- block_ack  in  1  round controller has consumed the block (64 rounds done)
- busy  out  1  message in progress (first accepted word through final block_ack)

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, blk_clr_n=1, block_valid=0, block_last=0, busy=0, length counter=0, word index=0.
- States: IDLE, CLR, LOAD, PAD, LEN_HI, LEN_LO, HANDOFF.
- IDLE: in_ready=1. An accepted word (in_valid & in_ready) sets busy and is processed as in LOAD.
- CLR: blk_clr_n=0 for exactly one cycle before the first write of every block after the first; index:=0; then return to LOAD or PAD as pending.
- LOAD: in_ready=1 while index<16. Accepted word is registered and written next cycle: wr_en=1, wr_addr=index, wr_data=word (1-cycle latency). Length += 8*in_nbytes.
- Last word, n<4: bytes [31:32-8n] kept, byte at position n set to 0x80, lower bytes zeroed, written at index. n=4: data written, then 0x80000000 written at index+1. n=0: 0x80000000 written at index (data ignored).
- After the marker: zeros written until index 13, then LEN_HI (length[63:32]) at 14 and LEN_LO (length[31:0]) at 15.
- If the marker occupies index 14 or 15: zeros fill to 15, block handed off with block_last=0, then a new block is written with zeros at 0..13 and length at 14..15.
- Block full (index 15 written): enter HANDOFF. block_valid=1, in_ready=0, no writes. block_ack in HANDOFF clears block_valid next cycle, then go to CLR (more data/padding pending) or IDLE (block_last was 1; busy cleared).
- block_ack outside HANDOFF is ignored. in_valid while in_ready=0 is ignored; data must be held.
- One write per cycle maximum; the padding states write one word per cycle without stalls.
- Length counter wraps modulo 2^LEN_W silently.
- reset_n low mid-message: all state returns to reset values immediately, partial block is abandoned, and no wr_en is issued until a new word is accepted.

Optional Feature:
- SHA256_LOADER_BSWAP_EN.
- Defined: in_data is byte-swapped (first byte in [7:0]) before padding; in_nbytes counts from the low byte.
- Undefined: in_data used as-is, big-endian.

Decomposition:
- Shared package sha256_pkg holds: state encoding, PAD_MARKER=32'h80000000, WORDS_PER_BLOCK=16, LEN_HI_IDX=14, LEN_LO_IDX=15.
- One sub-module, sha256_pad_word: combinational last-word masking, marker insertion, and optional byte swap.

Test Plan:
- "abc" (in_data=0x61626300, nbytes=3, last) → one block: W0=0x61626380, W1..W14=0, W15=0x00000018; block_last=1.
- Empty (nbytes=0, last) → W0=0x80000000, W1..W15=0, block_last=1.
- 56 bytes (14 full words, last nbytes=4) → block1: W14=0x80000000, W15=0, block_last=0; blk_clr_n pulse; block2: W0..W13=0, W14=0, W15=0x000001C0, block_last=1.
- 64 bytes with block_ack delayed 100 cycles → in_ready=0 and no wr_en during the wait; block2 W0=0x80000000, W15=0x00000200.
- Reset asserted mid-LOAD at index 7 → outputs return to reset values; a following "abc" message produces the correct single block.
- In-stream bubbles (in_valid toggling) → write addresses stay contiguous 0..15 with no duplicate or skipped writes.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block loader: FSM encoding, padding constants
// and the length-field word selector.
package sha256_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_PAD,
    S_LEN_HI,
    S_LEN_LO,
    S_HANDOFF
  } state_t;

  localparam logic [31:0] PAD_MARKER      = 32'h8000_0000;
  localparam int          WORDS_PER_BLOCK = 16;
  localparam logic [3:0]  LEN_HI_IDX      = 4'(WORDS_PER_BLOCK - 2);
  localparam logic [3:0]  LEN_LO_IDX      = 4'(WORDS_PER_BLOCK - 1);

  function automatic logic [31:0] len_word(input logic [63:0] len, input logic hi);
    return hi ? len[63:32] : len[31:0];
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word shaping: keeps the valid leading bytes, inserts the 0x80 marker and
// zeroes the rest. SHA256_LOADER_BSWAP_EN selects little-endian input byte order.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
  input  logic        i_last,
  output logic [31:0] o_word,
  output logic        o_marker
);

  logic [31:0] w_data;

  genvar gi;

`ifdef SHA256_LOADER_BSWAP_EN
  generate
    for (gi = 0; gi < 4; gi++) begin : g_swap
      assign w_data[8*gi +: 8] = i_data[31-8*gi -: 8];
    end
  endgenerate
`else
  assign w_data = i_data;
`endif

  // Byte gi counts from the most significant byte of the word.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte
      assign o_word[31-8*gi -: 8] =
        (!i_last || (i_nbytes > 3'(gi))) ? w_data[31-8*gi -: 8] :
        (i_nbytes == 3'(gi))             ? PAD_MARKER[31:24]    : 8'h00;
    end
  endgenerate

  assign o_marker = i_last && (i_nbytes < 3'd4);

endmodule

// File: rtl/sha256_block_loader.sv
// Streams message words into the SHA-256 scheduler memory with full padding and
// per-block handoff. Optional macro SHA256_LOADER_BSWAP_EN (see sha256_pad_word).
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        blk_clr_n,
  output logic        block_valid,
  output logic        block_last,
  input  logic        block_ack,
  output logic        busy
);

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [LEN_W-1:0] r_len;
  logic             r_mark_pend;
  logic             r_len_here;
  logic             r_pad;
  logic             r_final;
  logic             r_in_ready;
  logic             r_wr_en;
  logic [3:0]       r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_blk_clr_n;
  logic             r_block_valid;
  logic             r_block_last;
  logic             r_busy;

  logic [31:0]      w_pad_word;
  logic             w_marker;
  logic             w_accept;
  logic [LEN_W-1:0] w_len_add;
  logic [63:0]      w_len64;

  sha256_pad_word u_pad_word (
    .i_data   (in_data),
    .i_nbytes (in_nbytes),
    .i_last   (in_last),
    .o_word   (w_pad_word),
    .o_marker (w_marker)
  );

  assign w_accept  = in_valid && r_in_ready;
  assign w_len_add = r_len + LEN_W'({in_nbytes, 3'b000});
  assign w_len64   = 64'(r_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_len         <= '0;
      r_mark_pend   <= 1'b0;
      r_len_here    <= 1'b0;
      r_pad         <= 1'b0;
      r_final       <= 1'b0;
      r_in_ready    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_blk_clr_n   <= 1'b1;
      r_block_valid <= 1'b0;
      r_block_last  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_wr_en     <= 1'b0;
      r_blk_clr_n <= 1'b1;
      case (r_state)
        S_IDLE, S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_busy    <= 1'b1;
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_idx;
            r_wr_data <= w_pad_word;
            r_idx     <= r_idx + 4'd1;
            r_len     <= w_len_add;
            if (in_last) begin
              // A full final word leaves the marker for the next slot.
              r_in_ready  <= 1'b0;
              r_pad       <= 1'b1;
              r_mark_pend <= !w_marker;
              r_len_here  <= (r_idx < LEN_HI_IDX);
              if (r_idx == LEN_LO_IDX)
                r_state <= S_HANDOFF;
              else if (w_marker && (r_idx == LEN_HI_IDX - 4'd1))
                r_state <= S_LEN_HI;
              else
                r_state <= S_PAD;
            end else if (r_idx == LEN_LO_IDX) begin
              r_in_ready <= 1'b0;
              r_state    <= S_HANDOFF;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end

        S_CLR: begin
          r_len_here <= 1'b1;
          if (r_pad) begin
            r_state <= S_PAD;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_PAD: begin
          r_wr_en     <= 1'b1;
          r_wr_addr   <= r_idx;
          r_wr_data   <= r_mark_pend ? PAD_MARKER : 32'h0;
          r_idx       <= r_idx + 4'd1;
          r_mark_pend <= 1'b0;
          if (r_mark_pend)
            r_len_here <= (r_idx < LEN_HI_IDX);
          // Reaching slot 13 here means the marker sits at or below 13.
          if (r_idx == LEN_LO_IDX)
            r_state <= S_HANDOFF;
          else if (r_idx == LEN_HI_IDX - 4'd1)
            r_state <= S_LEN_HI;
        end

        S_LEN_HI: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          r_wr_data <= len_word(w_len64, 1'b1);
          r_idx     <= r_idx + 4'd1;
          r_state   <= S_LEN_LO;
        end

        S_LEN_LO: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_idx;
          r_wr_data <= len_word(w_len64, 1'b0);
          r_idx     <= r_idx + 4'd1;
          r_final   <= 1'b1;
          r_state   <= S_HANDOFF;
        end

        S_HANDOFF: begin
          if (!r_block_valid) begin
            r_block_valid <= 1'b1;
            r_block_last  <= r_final;
          end else if (block_ack) begin
            r_block_valid <= 1'b0;
            r_block_last  <= 1'b0;
            r_idx         <= '0;
            if (r_final) begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
              r_len       <= '0;
              r_final     <= 1'b0;
              r_pad       <= 1'b0;
              r_mark_pend <= 1'b0;
            end else begin
              r_state     <= S_CLR;
              r_blk_clr_n <= 1'b0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign blk_clr_n   = r_blk_clr_n;
  assign block_valid = r_block_valid;
  assign block_last  = r_block_last;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Scoreboard bench: expected writes, clear pulses and block handoffs are queued by
// the stimulus; a negedge monitor pops and compares each DUT event in order.
module tb_sha256_block_loader;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_BLK = 2'd1;
  localparam logic [1:0] K_CLR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        blk_clr_n;
  logic        block_valid;
  logic        block_last;
  logic        block_ack;
  logic        busy;

  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  ack_delay = 2;
  int  stall_bad = 0;
  logic prev_bv = 1'b0;

  sha256_block_loader #(.LEN_W(64)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .blk_clr_n   (blk_clr_n),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ack   (block_ack),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic push_ev(input logic [1:0] k, input logic [3:0] a, input logic [31:0] d, input logic l);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.last = l;
    q.push_back(e);
  endtask

  task automatic push_zeros(input int from, input int to);
    for (int a = from; a <= to; a++) push_ev(K_WR, 4'(a), 32'h0, 1'b0);
  endtask

  task automatic check_event(input logic [1:0] k, input logic [3:0] a, input logic [31:0] d, input logic l);
    ev_t e;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h last=%b, required none", k, a, d, l);
    end else begin
      e = q.pop_front();
      if (e.kind !== k || e.addr !== a || e.data !== d || e.last !== l) begin
        n_fail++;
        $display("FAIL event: got kind=%0d addr=%0d data=%h last=%b, required kind=%0d addr=%0d data=%h last=%b",
                 k, a, d, l, e.kind, e.addr, e.data, e.last);
      end else begin
        $display("[TB] event kind=%0d addr=%0d data=%h last=%b ok", k, a, d, l);
      end
    end
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("[TB] %s = %h ok", name, act);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_in_ready"},    32'(in_ready),    32'd0);
    check_eq({tag, "_wr_en"},       32'(wr_en),       32'd0);
    check_eq({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
    check_eq({tag, "_wr_data"},     wr_data,          32'd0);
    check_eq({tag, "_blk_clr_n"},   32'(blk_clr_n),   32'd1);
    check_eq({tag, "_block_valid"}, 32'(block_valid), 32'd0);
    check_eq({tag, "_block_last"},  32'(block_last),  32'd0);
    check_eq({tag, "_busy"},        32'(busy),        32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [2:0] n, input int gap);
    int   t;
    logic acc;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = n;
    t = 0; acc = 1'b0;
    while (!acc && t < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 1000 cycles", d);
    end
    if (l) in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while ((busy || q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_tests++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL %s_done: busy=%b pending=%0d after 3000 cycles, required busy=0 pending=0", tag, busy, q.size());
    end else begin
      $display("[TB] %s message complete ok", tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic expect_abc();
    push_ev(K_WR, 4'd0, 32'h6162_6380, 1'b0);
    push_zeros(1, 14);
    push_ev(K_WR, 4'd15, 32'h0000_0018, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_bv = 1'b0;
      end else begin
        if (wr_en) check_event(K_WR, wr_addr, wr_data, 1'b0);
        if (!blk_clr_n) check_event(K_CLR, 4'd0, 32'h0, 1'b0);
        if (block_valid && !prev_bv) check_event(K_BLK, 4'd0, 32'h0, block_last);
        prev_bv = block_valid;
      end
    end
  end

  // Round-controller model
  initial begin
    block_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && block_valid && !block_ack) begin
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk);
          if (in_ready || wr_en) stall_bad++;
        end
        @(posedge clk); #1 block_ack = 1'b1;
        @(posedge clk); #1 block_ack = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // "abc"
    expect_abc();
    send(32'h6162_6300, 1'b1, 3'd3, 0);
    check_eq("abc_busy", 32'(busy), 32'd1);
    wait_done("abc");

    // empty message
    push_ev(K_WR, 4'd0, 32'h8000_0000, 1'b0);
    push_zeros(1, 15);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
    send(32'hDEAD_BEEF, 1'b1, 3'd0, 0);
    wait_done("empty");

    // 55 bytes: marker lands at index 13, length fits
    for (int i = 0; i < 13; i++) push_ev(K_WR, 4'(i), 32'h5A5A_0000 + 32'(i), 1'b0);
    push_ev(K_WR, 4'd13, 32'h5A5A_0080, 1'b0);
    push_ev(K_WR, 4'd14, 32'h0, 1'b0);
    push_ev(K_WR, 4'd15, 32'h0000_01B8, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 13; i++) send(32'h5A5A_0000 + 32'(i), 1'b0, 3'd4, 0);
    send(32'h5A5A_000D, 1'b1, 3'd3, 0);
    wait_done("b55");

    // 56 bytes with bubbles: marker at 14 forces a second block
    for (int i = 0; i < 14; i++) push_ev(K_WR, 4'(i), 32'h5A5A_0000 + 32'(i), 1'b0);
    push_ev(K_WR, 4'd14, 32'h8000_0000, 1'b0);
    push_ev(K_WR, 4'd15, 32'h0, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b0);
    push_ev(K_CLR, 4'd0, 32'h0, 1'b0);
    push_zeros(0, 14);
    push_ev(K_WR, 4'd15, 32'h0000_01C0, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 14; i++) send(32'h5A5A_0000 + 32'(i), (i == 13), 3'd4, i % 3);
    wait_done("b56");

    // 64 bytes, slow acknowledge
    ack_delay = 100;
    stall_bad = 0;
    for (int i = 0; i < 16; i++) push_ev(K_WR, 4'(i), 32'hC300_0000 + 32'(i), 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b0);
    push_ev(K_CLR, 4'd0, 32'h0, 1'b0);
    push_ev(K_WR, 4'd0, 32'h8000_0000, 1'b0);
    push_zeros(1, 14);
    push_ev(K_WR, 4'd15, 32'h0000_0200, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 16; i++) send(32'hC300_0000 + 32'(i), (i == 15), 3'd4, 0);
    wait_done("b64");
    check_eq("b64_stall_activity", 32'(stall_bad), 32'd0);
    ack_delay = 2;

    // reset in the middle of a block at index 7
    for (int i = 0; i < 7; i++) push_ev(K_WR, 4'(i), 32'h1111_0000 + 32'(i), 1'b0);
    for (int i = 0; i < 7; i++) send(32'h1111_0000 + 32'(i), 1'b0, 3'd4, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_pending", 32'(q.size()), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    expect_abc();
    send(32'h6162_6300, 1'b1, 3'd3, 0);
    wait_done("abc_after_rst");

    // 10 bytes with in_valid bubbles
    push_ev(K_WR, 4'd0, 32'h4142_4344, 1'b0);
    push_ev(K_WR, 4'd1, 32'h4546_4748, 1'b0);
    push_ev(K_WR, 4'd2, 32'h494A_8000, 1'b0);
    push_zeros(3, 14);
    push_ev(K_WR, 4'd15, 32'h0000_0050, 1'b0);
    push_ev(K_BLK, 4'd0, 32'h0, 1'b1);
    send(32'h4142_4344, 1'b0, 3'd4, 3);
    send(32'h4546_4748, 1'b0, 3'd4, 1);
    send(32'h494A_FFFF, 1'b1, 3'd2, 2);
    wait_done("bubbles");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
